// File: rtl/pll_lock_sequencer.sv
// Sequences the rPLL: reset pulses, lock qualification, retry/fail, and safe runtime
// phase/duty changes applied under core reset. Clocked by the raw board clock only.
module pll_lock_sequencer #(
  parameter int         RST_CYCLES    = 32,
  parameter int         LOCK_STABLE   = 1024,
  parameter int         LOCK_TIMEOUT  = 65535,
  parameter int         MAX_RETRY     = 3,
  parameter int         SETTLE_CYCLES = 256,
  parameter int         HOLD_CYCLES   = 16,
  parameter logic [3:0] PSDA_INIT     = 4'h0,
  parameter logic [3:0] DUTY_INIT     = 4'h8
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       pll_reset_p,
  output logic [3:0] pll_psda,
  output logic [3:0] pll_dutyda,
  input  logic       cfg_valid,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_dutyda,
  output logic       cfg_ready,
  output logic       sys_reset,
  output logic       pll_locked,
  output logic       pll_fail,
  output logic [7:0] relock_count
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(max2(RST_CYCLES, LOCK_STABLE),
                                     max2(LOCK_TIMEOUT, SETTLE_CYCLES)), HOLD_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN,
    CFG_APPLY,
    CFG_SETTLE,
    FAIL
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retry_inc;
  logic [3:0]         psda_lat;
  logic [3:0]         duty_lat;
  logic               lock_meta;
  logic               lock_s;
  logic               lock_lost;

  // pll_lock is asynchronous to clkin; only lock_s may steer the state machine.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  assign retry_inc = retry + RETRY_W'(1);
  assign lock_lost = !lock_s && ((state == HOLD) || (state == RUN) ||
                                 (state == CFG_APPLY) || (state == CFG_SETTLE));

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state        <= PLL_RST;
      cnt          <= '0;
      retry        <= '0;
      pll_reset    <= 1'b1;
      pll_reset_p  <= 1'b1;
      sys_reset    <= 1'b1;
      pll_psda     <= PSDA_INIT;
      pll_dutyda   <= DUTY_INIT;
      psda_lat     <= PSDA_INIT;
      duty_lat     <= DUTY_INIT;
      cfg_ready    <= 1'b0;
      pll_locked   <= 1'b0;
      pll_fail     <= 1'b0;
      relock_count <= 8'd0;
    end else if (lock_lost) begin
      // Lock loss wins over any handshake; phase/duty settings survive the relock.
      state       <= PLL_RST;
      cnt         <= '0;
      pll_reset   <= 1'b1;
      pll_reset_p <= 1'b1;
      sys_reset   <= 1'b1;
      cfg_ready   <= 1'b0;
      pll_locked  <= 1'b0;
      if (relock_count != 8'hFF) relock_count <= relock_count + 8'd1;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            pll_reset   <= 1'b0;
            pll_reset_p <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt         <= '0;
            retry       <= retry_inc;
            pll_reset   <= 1'b1;
            pll_reset_p <= 1'b1;
            if (retry_inc == RETRY_MAX) begin
              state    <= FAIL;
              pll_fail <= 1'b1;
            end else begin
              state <= PLL_RST;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state      <= HOLD;
            cnt        <= '0;
            pll_locked <= 1'b1;
            retry      <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_reset <= 1'b0;
            cfg_ready <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (cfg_valid && cfg_ready) begin
            psda_lat  <= cfg_psda;
            duty_lat  <= cfg_dutyda;
            state     <= CFG_APPLY;
            cnt       <= '0;
            cfg_ready <= 1'b0;
            sys_reset <= 1'b1;
          end
        end
        CFG_APPLY: begin
          pll_psda    <= psda_lat;
          pll_dutyda  <= duty_lat;
          pll_reset_p <= 1'b1;
          state       <= CFG_SETTLE;
          cnt         <= '0;
        end
        CFG_SETTLE: begin
          // The RESET_P pulse covers the first RST_CYCLES of the settle window.
          if (cnt == RST_LAST) pll_reset_p <= 1'b0;
          if (cnt == SETTLE_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        FAIL: begin
          pll_fail    <= 1'b1;
          pll_reset   <= 1'b1;
          pll_reset_p <= 1'b1;
          sys_reset   <= 1'b1;
          cfg_ready   <= 1'b0;
        end
        default: begin
          state <= PLL_RST;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
